// File: rtl/perm_pkg.sv
// perm_pkg: shared FSM state type and lane-rotation selector helper for perm_sel_gen.
package perm_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} perm_state_t;
  localparam int P_N = 4;
  localparam int P_SELW = 2;
  localparam bit P_SEL_OK = P_SELW == $clog2(P_N);
  function automatic logic [P_N*P_SELW-1:0] rot_sel(input logic [P_SELW-1:0] rot);
    logic [P_N*P_SELW-1:0] s;
    s = '0;
    for (int i = 0; i < P_N; i++) s[i*P_SELW +: P_SELW] = P_SELW'(i) + rot;
    return s;
  endfunction
endpackage

// File: rtl/perm_sel_gen_out_reg.sv
// perm_out_reg: single-entry valid/ready output register holding beat data and selector.
module perm_out_reg #(
  parameter int DW = 32,
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          ready,
  input  logic [DW-1:0] d,
  input  logic [SW-1:0] s,
  output logic          valid,
  output logic [DW-1:0] q,
  output logic [SW-1:0] sel
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
      sel   <= '0;
    end else begin
      valid <= load | (valid & ~ready);
      if (load) begin
        q   <= d;
        sel <= s;
      end
    end
  end
endmodule

// File: rtl/perm_sel_gen.sv
// perm_sel_gen: counts beats/stages of a transform pass and emits registered
// lane-rotation selectors alongside each accepted beat for the scatter network.
module perm_sel_gen
  import perm_pkg::*;
#(
  parameter int N      = 4,
  parameter int W      = 8,
  parameter int SELW   = 2,
  parameter int BEATS  = 4,
  parameter int STAGES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*W-1:0]    in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*W-1:0]    out_data,
  output logic [N*SELW-1:0] out_sel,
  output logic              busy,
  output logic              done
);
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int SW = STAGES > 1 ? $clog2(STAGES) : 1;

  if (SELW != $clog2(N) || N < 2 || (N & (N - 1)) != 0) begin : g_bad_cfg
    $error("perm_sel_gen: N must be a power of two >= 2 and SELW == clog2(N)");
  end

  perm_state_t state, state_n;
  logic [BW-1:0] beat_cnt;
  logic [SW-1:0] stage_cnt;
  logic [SELW-1:0] rot;
  logic [N*SELW-1:0] sel_n;
  logic accept, beat_last, pass_last, drain_ok;

  assign in_ready  = state == RUN && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign beat_last = beat_cnt == BW'(BEATS - 1);
  assign pass_last = beat_last && stage_cnt == SW'(STAGES - 1);
  assign drain_ok  = !out_valid || out_ready;
  assign busy      = state != IDLE;
  assign done      = state == DRAIN && drain_ok;
  // Low SELW bits of each counter sum to the same value mod N as the full sum.
  assign rot       = SELW'(beat_cnt) + SELW'(stage_cnt);

  if (N == P_N && SELW == P_SELW && P_SEL_OK) begin : g_pkg_sel
    assign sel_n = rot_sel(rot);
  end else begin : g_gen_sel
    always_comb begin
      sel_n = '0;
      for (int i = 0; i < N; i++) sel_n[i*SELW +: SELW] = SELW'(i) + rot;
    end
  end

  always_comb begin
    state_n = (state == IDLE && start)               ? RUN   :
              (state == RUN && accept && pass_last)  ? DRAIN :
              (state == DRAIN && drain_ok)           ? IDLE  : state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      stage_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        beat_cnt  <= '0;
        stage_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
        if (beat_last) stage_cnt <= stage_cnt + 1'b1;
      end
    end
  end

  perm_out_reg #(.DW(N*W), .SW(N*SELW)) u_out (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .ready (out_ready),
    .d     (in_data),
    .s     (sel_n),
    .valid (out_valid),
    .q     (out_data),
    .sel   (out_sel)
  );
endmodule
